// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key decoder: prefix bytes, ignored bytes,
// ps2_key field layout.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // Keyboard housekeeping bytes (BAT, echo, ack, resend, errors) that never form a key event.
  localparam int unsigned PS2_N_IGNORED = 6;
  localparam logic [PS2_N_IGNORED-1:0][7:0] PS2_IGNORED =
    {8'hFF, 8'hFE, 8'hFA, 8'hEE, 8'hAA, 8'h00};

  localparam int unsigned KEY_TOGGLE  = 10;
  localparam int unsigned KEY_PRESSED = 9;
  localparam int unsigned KEY_EXT     = 8;

  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

  function automatic logic ps2_is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_N_IGNORED; i++) begin
      if (PS2_IGNORED[i] == b) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, clock-fall detect, shift register and frame checks.
// Optional partial-frame watchdog when PS2_WATCHDOG_EN is defined.
module ps2_frame_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_bad
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_frame_rx: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [9:0]             shift_q, shift_d;
  logic                   valid_q, valid_d;
  logic                   bad_q, bad_d;
  logic [7:0]             byte_q, byte_d;
  logic                   clk_s, data_s, fall;

`ifdef PS2_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
    clk_prev_d  = clk_s;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    valid_d     = 1'b0;
    bad_d       = 1'b0;

    if (fall) begin
      if (bitcnt_q == 4'd10) begin
        // shift_q holds {parity, data[7:0], start}; the stop bit is on the line now.
        bitcnt_d = 4'd0;
        if (!shift_q[0] && (^shift_q[9:1]) && data_s) begin
          valid_d = 1'b1;
          byte_d  = shift_q[8:1];
        end else begin
          bad_d = 1'b1;
        end
      end else begin
        shift_d  = {data_s, shift_q[9:1]};
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end

`ifdef PS2_WATCHDOG_EN
    wdog_d = wdog_q;
    if (fall || bitcnt_q == 4'd0) begin
      wdog_d = '0;
    end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES)) begin
      wdog_d   = '0;
      bitcnt_d = 4'd0;
      bad_d    = 1'b1;
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the synchroniser resets low too, so a line already low at release cannot look like a fall.
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      bitcnt_q    <= 4'd0;
      shift_q     <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      bad_q       <= 1'b0;
`ifdef PS2_WATCHDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      bad_q       <= bad_d;
`ifdef PS2_WATCHDOG_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign byte_valid = valid_q;
  assign rx_byte    = byte_q;
  assign frame_bad  = bad_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder producing the 11-bit {toggle, pressed, extended, code} ps2_key event word.
// Define PS2_WATCHDOG_EN to abort partial frames after TIMEOUT_CYCLES idle clocks.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  logic       byte_valid, frame_bad;
  logic [7:0] rx_byte;
  ps2_key_t   key_q, key_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       err_q, err_d;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_bad  (frame_bad)
  );

  // Prefixes accumulate until a code or housekeeping byte consumes them.
  always_comb begin
    key_d = key_q;
    ext_d = ext_q;
    brk_d = brk_q;
    err_d = 1'b0;
    if (frame_bad) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
      err_d = 1'b1;
    end else if (byte_valid) begin
      if (rx_byte == PS2_PFX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_PFX_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ps2_is_ignored(rx_byte)) begin
          key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
          key_d[KEY_PRESSED] = ~brk_q;
          key_d[KEY_EXT]     = ext_q;
          key_d.code         = rx_byte;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      key_q <= key_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      err_q <= err_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;

endmodule
